rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one resource (bus port, functional unit, CSR access path) between N requesters.
- Rotating-priority pick uses two instances of the lzd leading-zero detector (base B): one on priority-masked requests, one on raw requests.
- Grant is registered and locked until the holder signals done, or an optional hold limit forces preemption.
- Sits between requester clients and the shared datapath resource in the core.

Parameters:
- N, 4, number of requesters; power of 2, >= 2 (lzd constraint).
- B, 4, lzd base; 2 or 4, passed to both lzd instances.
- MAX_HOLD, 0, maximum grant length in cycles before forced preemption; 0 disables preemption.
- M (localparam), $clog2(N), grant index width.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_req  input  N  per-requester request level; bit k = requester k.
- i_done  input  1  holder finished; sampled only while o_grant_valid=1.
- o_grant  output  N  one-hot grant, registered.
- o_grant_index  output  M  index of granted requester, registered.
- o_grant_valid  output  1  a grant is active.
- o_preempt  output  1  one-cycle pulse: current grant removed by hold limit.

Behaviour:
- Reset (async assert, sync release):
  - o_grant=0, o_grant_index=0, o_grant_valid=0, o_preempt=0.
  - Priority pointer ptr=N-1; hold counter=0; state IDLE.
- Selection function, purely combinational:
  - masked = i_req AND bits strictly above ptr.
  - If masked != 0, winner = lzd(masked), i.e. lowest set index above ptr.
  - Else winner = lzd(i_req) (wrap to lowest set index).
  - valid = OR of i_req.
  - Requester ptr+1 (mod N) has highest priority.
- States: IDLE, GRANT.
- IDLE:
  - If valid: next edge -> GRANT, o_grant=onehot(winner), o_grant_index=winner, o_grant_valid=1, counter=0.
  - Else stay IDLE.
  - Latency from req assert to grant: 1 cycle.
- GRANT:
  - Grant held unchanged regardless of i_req; the holder dropping its req does not release.
  - Release event = i_done=1, OR (MAX_HOLD!=0 AND counter==MAX_HOLD-1 AND i_done=0).
  - On release: ptr <= o_grant_index; arbitration reruns using the current grant index as ptr.
    - If valid: new grant registered at the same edge; no idle bubble. The holder may be regranted only if it is the sole requester.
    - Else: -> IDLE, grant outputs cleared to 0.
  - Counter: increments each GRANT cycle without release; resets to 0 on any new grant.
- o_preempt:
  - Pulses 1 cycle on the edge after a hold-limit release.
  - i_done has priority: if i_done=1 on the limit cycle, no preempt.
- Invariants:
  - o_grant always one-hot or zero.
  - o_grant == onehot(o_grant_index) when valid.
  - No grant to a requester whose req was 0 at decision time.
- Reset mid-GRANT: outputs clear immediately (async); ptr returns to N-1.
- Parameter checks: generate-time $error if N is not a power of 2 >= 2, B is not 2 or 4, or MAX_HOLD < 0.

Test Plan:
- Reset, then i_req=4'b0110 -> one cycle later o_grant=4'b0010, o_grant_index=1, o_grant_valid=1, o_preempt=0.
- Holder 1, i_req=4'b0110 held, pulse i_done -> next cycle o_grant=4'b0100, index 2, valid never drops.
- Holder 2, i_req=4'b0011, i_done -> wrap: o_grant=4'b0001, index 0. Then i_req=4'b0001, i_done -> regrant 0. Then i_req=0, i_done -> valid=0, grant=0.
- Holder 1 drops i_req with no i_done for 10 cycles -> o_grant stays 4'b0010 throughout.
- MAX_HOLD=4, i_req=4'b1001, holder 0, i_done=0 -> after 4 grant cycles o_preempt=1 for one cycle, o_grant=4'b1000. Repeat with i_done=1 on cycle 4 -> o_preempt stays 0.
- Assert i_rst asynchronously mid-grant (no clock edge) -> all outputs 0 immediately. After release, i_req=4'b1111 -> grant index 0.

Source files
------------

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with locked grants, done-release and optional hold-limit preemption
module lzd #(
  parameter int N = 4,
  parameter int B = 4,
  localparam int M = $clog2(N)
) (
  input  logic [N-1:0] bits,
  output logic [M-1:0] idx,
  output logic         valid
);
  if (N <= B) begin : g_leaf
    always_comb begin
      idx = '0;
      for (int k = N - 1; k >= 0; k--) idx = bits[k] ? M'(k) : idx;
    end
    assign valid = |bits;
  end else begin : g_node
    localparam int S = N / B;
    localparam int SM = $clog2(S);
    localparam int LB = $clog2(B);
    logic [SM-1:0] cidx [B];
    logic [B-1:0] cv;
    logic [LB-1:0] sel;
    for (genvar c = 0; c < B; c++) begin : g_c
      lzd #(.N(S), .B(B)) u_lzd (.bits(bits[c*S +: S]), .idx(cidx[c]), .valid(cv[c]));
    end
    always_comb begin
      sel = '0;
      for (int k = B - 1; k >= 0; k--) sel = cv[k] ? LB'(k) : sel;
    end
    assign idx = {sel, cidx[sel]};
    assign valid = |cv;
  end
endmodule

module rr_arbiter #(
  parameter int N = 4,
  parameter int B = 4,
  parameter int MAX_HOLD = 0,
  localparam int M = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  input  logic         i_done,
  output logic [N-1:0] o_grant,
  output logic [M-1:0] o_grant_index,
  output logic         o_grant_valid,
  output logic         o_preempt
);
  localparam int CW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] LIM = CW'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);
  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("rr_arbiter: N must be a power of 2 >= 2");
  end
  if (B != 2 && B != 4) begin : g_bad_b
    $error("rr_arbiter: B must be 2 or 4");
  end
  if (MAX_HOLD < 0) begin : g_bad_hold
    $error("rr_arbiter: MAX_HOLD must be >= 0");
  end
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [M-1:0] ptr, ptr_n, idx_n, sel_ptr, m_idx, r_idx, win;
  logic [N-1:0] above, masked, grant_n;
  logic [CW-1:0] cnt, cnt_n;
  logic m_v, r_v, lim, rel, pre_n;
  // while granted, the holder itself is the rotation point
  assign sel_ptr = state == GRANT ? o_grant_index : ptr;
  always_comb begin
    above = '0;
    for (int k = 0; k < N; k++) above[k] = k > int'(sel_ptr);
  end
  assign masked = i_req & above;
  lzd #(.N(N), .B(B)) u_masked (.bits(masked), .idx(m_idx), .valid(m_v));
  lzd #(.N(N), .B(B)) u_raw (.bits(i_req), .idx(r_idx), .valid(r_v));
  assign win = m_v ? m_idx : r_idx;
  assign lim = MAX_HOLD != 0 && state == GRANT && cnt == LIM && !i_done;
  assign rel = state == GRANT && (i_done || lim);
  always_comb begin
    state_n = state;
    grant_n = o_grant;
    idx_n = o_grant_index;
    ptr_n = rel ? o_grant_index : ptr;
    cnt_n = cnt + CW'(1);
    pre_n = lim;
    if (state == IDLE || rel) begin
      state_n = r_v ? GRANT : IDLE;
      grant_n = r_v ? N'(1) << win : '0;
      idx_n = r_v ? win : '0;
      cnt_n = '0;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      o_grant <= '0;
      o_grant_index <= '0;
      o_preempt <= 1'b0;
      ptr <= M'(N - 1);
      cnt <= '0;
    end else begin
      state <= state_n;
      o_grant <= grant_n;
      o_grant_index <= idx_n;
      o_preempt <= pre_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
    end
  end
  assign o_grant_valid = state == GRANT;
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: scoreboard bench for rr_arbiter, one instance without and one with a hold limit of 4
module tb_rr_arbiter;
  logic clk = 0, i_rst = 1, i_done = 0;
  logic [3:0] i_req = '0;
  logic [3:0] g0, g4;
  logic [1:0] x0, x4;
  logic v0, v4, p0, p4;
  int checks = 0, passes = 0;
  typedef struct packed {logic [3:0] g; logic [1:0] i; logic v; logic p;} exp_t;
  exp_t q0[$], q4[$];
  logic busy [2];
  logic pre [2];
  int holder [2], ptr [2], cnt [2];
  int mh [2] = '{0, 4};

  always #5 clk = ~clk;

  rr_arbiter #(.N(4), .B(4), .MAX_HOLD(0)) d0 (.i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_done(i_done),
    .o_grant(g0), .o_grant_index(x0), .o_grant_valid(v0), .o_preempt(p0));
  rr_arbiter #(.N(4), .B(2), .MAX_HOLD(4)) d4 (.i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_done(i_done),
    .o_grant(g4), .o_grant_index(x4), .o_grant_valid(v4), .o_preempt(p4));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int pick(logic [3:0] req, int p);
    for (int k = 1; k <= 4; k++) if (req[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  task automatic model_step(int d, logic rst, logic [3:0] req, logic done);
    logic limit;
    if (rst) begin
      busy[d] = 0; holder[d] = 0; ptr[d] = 3; cnt[d] = 0; pre[d] = 0;
    end else if (!busy[d]) begin
      pre[d] = 0;
      if (req != 0) begin
        holder[d] = pick(req, ptr[d]); busy[d] = 1; cnt[d] = 0;
      end
    end else begin
      limit = mh[d] != 0 && cnt[d] == mh[d] - 1 && !done;
      pre[d] = limit;
      if (done || limit) begin
        ptr[d] = holder[d];
        cnt[d] = 0;
        if (req != 0) holder[d] = pick(req, holder[d]);
        else begin
          busy[d] = 0; holder[d] = 0;
        end
      end else cnt[d]++;
    end
  endtask

  function automatic exp_t expected(int d);
    return '{g: busy[d] ? 4'(1 << holder[d]) : 4'd0, i: busy[d] ? 2'(holder[d]) : 2'd0, v: busy[d], p: pre[d]};
  endfunction

  task automatic push_model(logic rst, logic [3:0] req, logic done);
    for (int d = 0; d < 2; d++) model_step(d, rst, req, done);
    q0.push_back(expected(0));
    q4.push_back(expected(1));
  endtask

  task automatic cyc(logic rst, logic [3:0] req, logic done);
    @(negedge clk);
    i_rst = rst; i_req = req; i_done = done;
    push_model(rst, req, done);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic async_rst();
    @(negedge clk);
    #2;
    i_rst = 1;
    #1;
    chk("async_g0", g0, 0); chk("async_v0", v0, 0); chk("async_x0", x0, 0); chk("async_p0", p0, 0);
    chk("async_g4", g4, 0); chk("async_v4", v4, 0); chk("async_x4", x4, 0); chk("async_p4", p4, 0);
    push_model(1, i_req, i_done);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q0.size() != 0) begin
      e = q0.pop_front();
      chk("d0_grant", g0, e.g); chk("d0_index", x0, e.i); chk("d0_valid", v0, e.v); chk("d0_preempt", p0, e.p);
    end
    if (q4.size() != 0) begin
      e = q4.pop_front();
      chk("d4_grant", g4, e.g); chk("d4_index", x4, e.i); chk("d4_valid", v4, e.v); chk("d4_preempt", p4, e.p);
    end
  end

  initial begin
    repeat (3) cyc(1, 4'b0000, 0);
    cyc(0, 4'b0110, 0);
    settle();
    chk("first_grant", g0, 4'b0010); chk("first_index", x0, 1); chk("first_valid", v0, 1); chk("first_preempt", p0, 0);
    cyc(0, 4'b0110, 0);
    cyc(0, 4'b0110, 1);
    settle();
    chk("rotate_grant", g0, 4'b0100); chk("rotate_valid", v0, 1);
    cyc(0, 4'b0011, 1);
    settle();
    chk("wrap_grant", g0, 4'b0001);
    cyc(0, 4'b0001, 1);
    settle();
    chk("regrant_sole", g0, 4'b0001);
    cyc(0, 4'b0000, 1);
    settle();
    chk("idle_valid", v0, 0); chk("idle_grant", g0, 0);
    cyc(0, 4'b0010, 0);
    repeat (10) cyc(0, 4'b0000, 0);
    settle();
    chk("hold_after_drop", g0, 4'b0010);
    cyc(0, 4'b0000, 1);
    repeat (2) cyc(1, 4'b0000, 0);
    cyc(0, 4'b1001, 0);
    repeat (4) cyc(0, 4'b1001, 0);
    settle();
    chk("limit_preempt", p4, 1); chk("limit_grant", g4, 4'b1000);
    cyc(0, 4'b1001, 0);
    settle();
    chk("preempt_pulse_end", p4, 0);
    cyc(0, 4'b1001, 0);
    cyc(0, 4'b1001, 0);
    cyc(0, 4'b1001, 1);
    settle();
    chk("done_beats_limit", p4, 0); chk("done_grant", g4, 4'b0001);
    async_rst();
    cyc(0, 4'b1111, 0);
    settle();
    chk("post_reset_index", x4, 0); chk("post_reset_valid", v4, 1); chk("post_reset_index_d0", x0, 0);
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(199) == 0, 4'($urandom), $urandom_range(2) == 0);
    repeat (2) settle();
    chk("drain_q0", q0.size(), 0);
    chk("drain_q4", q4.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
